// File: rtl/fetch_queue_if.sv
// Fetch-queue signal bundle: memory request/response, ID-side handshake and MEM redirect.
// The master side is the fetch queue itself; the slave side is its environment.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_instr;
  logic [31:0]      id_pc4;
  logic [CNT_W-1:0] count;

  modport master (
    input  redirect, redirect_pc, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_instr, id_pc4, count
  );

  modport slave (
    output redirect, redirect_pc, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc4, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, keeps at most one word fetch in flight and
// buffers {pc+4, instr} pairs for the IF/ID register; a MEM redirect flushes and refetches.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_queue_if.master bus
);
  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   fetch_pc;
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   instr_mem [DEPTH];
  logic [DATA_W-1:0]   pc4_mem   [DEPTH];

  logic                issue, push, pop, room, id_valid;
  logic [CNT_W:0]      occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Capacity check counts the outstanding kept response but ignores a same-cycle pop.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    occ       = {1'b0, count} + {{CNT_W{1'b0}}, (state == WAIT)};
    room      = (occ < (CNT_W + 1)'(DEPTH));
    if (bus.redirect) begin
      state_nxt = (state != IDLE && !bus.imem_rvalid) ? DROP : IDLE;
    end else begin
      case (state)
        IDLE: begin
          issue     = room;
          state_nxt = room ? WAIT : IDLE;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            push      = 1'b1;
            issue     = room;
            state_nxt = room ? WAIT : IDLE;
          end
        end
        DROP: begin
          if (bus.imem_rvalid) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign id_valid = (count != '0);
  assign pop      = id_valid && bus.id_ready && !bus.redirect;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      if (push)  tail     <= ptr_inc(tail);
      if (pop)   head     <= ptr_inc(head);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // In WAIT the fetch PC has already advanced past the outstanding request, so it is that request's pc+4.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[tail] <= bus.imem_rdata;
      pc4_mem[tail]   <= fetch_pc;
    end
  end

  assign bus.imem_req  = issue && !rst_i;
  assign bus.imem_addr = fetch_pc;
  assign bus.id_valid  = id_valid;
  assign bus.id_instr  = id_valid ? instr_mem[head] : '0;
  assign bus.id_pc4    = id_valid ? pc4_mem[head]   : '0;
  assign bus.count     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue: a variable-latency memory model plus a
// queue-level reference of the fetch rules, compared against the DUT every cycle.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // stimulus controls
  logic        redir = 1'b0;
  logic [31:0] rpc   = '0;
  logic        ready = 1'b0;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] salt  = '0;

  // memory model
  bit          mem_busy = 0;
  int          mem_due  = 0;
  logic [31:0] mem_addr = '0;

  // reference model: queue of {pc4, instr}, fetch pc, outstanding/discard flags
  logic [63:0] mq[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_req_addr = '0;
  bit          m_out = 0, m_disc = 0;

  // observed outputs of the last cycle
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_instr, obs_pc4, obs_count;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a >> 2) ^ salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic cycle();
    logic        rv, keep, exp_req, exp_valid;
    logic [31:0] rd;
    int          occ;
    rv = mem_busy && (mem_due == cyc);
    rd = rv ? word(mem_addr) : $urandom;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.id_ready    = ready;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    #1;
    obs_req   = bus.imem_req;
    obs_addr  = bus.imem_addr;
    obs_valid = bus.id_valid;
    obs_instr = bus.id_instr;
    obs_pc4   = bus.id_pc4;
    obs_count = 32'(bus.count);

    exp_valid = (mq.size() != 0);
    keep      = m_out && !m_disc && rv;
    occ       = mq.size() + ((m_out && !m_disc) ? 1 : 0);
    exp_req   = !redir && (!m_out || keep) && (occ < DEPTH);
    chk("imem_req", 32'(obs_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", obs_addr, m_pc);
    chk("id_valid", 32'(obs_valid), 32'(exp_valid));
    chk("count", obs_count, 32'(mq.size()));
    if (exp_valid) begin
      chk("id_instr", obs_instr, mq[0][31:0]);
      chk("id_pc4", obs_pc4, mq[0][63:32]);
    end

    if (redir) begin
      mq.delete();
      m_pc   = rpc;
      m_out  = m_out && !rv;
      m_disc = m_out;
    end else begin
      if (exp_valid && ready) void'(mq.pop_front());
      if (keep) mq.push_back({m_req_addr + 32'd4, rd});
      if (m_out && rv) m_out = 0;
      if (exp_req) begin
        m_out      = 1;
        m_disc     = 0;
        m_req_addr = m_pc;
        m_pc       = m_pc + 32'd4;
      end
    end

    // the memory answers whatever the DUT actually requested
    if (rv) mem_busy = 0;
    if (obs_req) begin
      if (mem_busy) begin
        checks++;
        errors++;
        $display("FAIL mem_protocol: request while busy, got %h expected idle (cycle %0d)", obs_addr, cyc);
      end
      mem_busy = 1;
      mem_due  = cyc + int'($urandom_range(lat_max, lat_min));
      mem_addr = obs_addr;
    end
    @(negedge clk);
    cyc++;
  endtask

  // Asserted at a falling edge so the asynchronous clear is seen before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.imem_rvalid = 1'b0;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_instr", bus.id_instr, 32'd0);
    chk("rst_pc4", bus.id_pc4, 32'd0);
    mq.delete();
    m_pc = RESET_PC; m_out = 0; m_disc = 0;
    mem_busy = 0;
    redir = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, k;
    bit  found;
    bus.redirect = 0; bus.redirect_pc = 0; bus.id_ready = 0;
    bus.imem_rvalid = 0; bus.imem_rdata = 0;
    @(negedge clk);

    // streaming at L=1, word[n]=n
    salt = 0; lat_min = 1; lat_max = 1; ready = 1;
    do_reset();
    cycle();
    chk("p1_first_req", 32'(obs_req), 32'd1);
    chk("p1_first_addr", obs_addr, RESET_PC);
    cycle();
    chk("p1_addr1", obs_addr, 32'd4);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("p1_valid", 32'(obs_valid), 32'd1);
      chk("p1_instr", obs_instr, 32'(i));
      chk("p1_pc4", obs_pc4, 32'(4 * i + 4));
    end

    // consumer stalled: exactly DEPTH requests, then drain in order
    ready = 0;
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_req) n++;
    end
    chk("p2_nreq", 32'(n), 32'(DEPTH));
    chk("p2_count", obs_count, 32'(DEPTH));
    chk("p2_req_off", 32'(obs_req), 32'd0);
    ready = 1;
    cycle();
    chk("p2_head", obs_instr, 32'd0);
    for (int i = 0; i < 12; i++) cycle();

    // redirect one cycle after the 0x20 request, L=3
    lat_min = 3; lat_max = 3; ready = 1;
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (obs_req && obs_addr == 32'h20) found = 1;
    end
    if (!found) begin checks++; errors++; $display("FAIL p3_wait: got timeout expected request to 00000020"); end
    redir = 1; rpc = 32'h100;
    cycle();
    chk("p3_redir_req", 32'(obs_req), 32'd0);
    redir = 0;
    found = 0; k = 0;
    for (int i = 1; i <= 10 && !found; i++) begin
      cycle();
      if (i == 1) chk("p3_count", obs_count, 32'd0);
      if (obs_req) begin found = 1; k = i; end
    end
    chk("p3_req_delay", 32'(k), 32'd3);
    chk("p3_req_addr", obs_addr, 32'h100);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (obs_valid) found = 1;
    end
    chk("p3_delivered", 32'(found), 32'd1);
    chk("p3_pc4", obs_pc4, 32'h104);
    chk("p3_instr", obs_instr, 32'h40);

    // redirect coinciding with a kept response while two entries are buffered
    lat_min = 2; lat_max = 2; ready = 0;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mq.size() == 2 && mem_busy && mem_due == cyc && m_out && !m_disc) begin
        redir = 1; rpc = 32'h200; found = 1;
      end
      cycle();
      redir = 0;
    end
    chk("p4_hit", 32'(found), 32'd1);
    cycle();
    chk("p4_count", obs_count, 32'd0);
    chk("p4_req", 32'(obs_req), 32'd1);
    chk("p4_addr", obs_addr, 32'h200);

    // full FIFO with random ready at L=1
    salt = $urandom; lat_min = 1; lat_max = 1; ready = 0;
    do_reset();
    for (int i = 0; i < 6; i++) cycle();
    chk("p5_full", obs_count, 32'(DEPTH));
    for (int i = 0; i < 120; i++) begin
      ready = $urandom_range(1, 0) != 0;
      cycle();
    end

    // reset while waiting with three entries buffered
    lat_min = 2; lat_max = 2; ready = 0;
    do_reset();
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mq.size() == 3 && m_out) found = 1;
      else cycle();
    end
    chk("p6_reached", 32'(found), 32'd1);
    do_reset();
    cycle();
    chk("p6_first_req", 32'(obs_req), 32'd1);
    chk("p6_first_addr", obs_addr, RESET_PC);

    // random soak: latency, ready, redirects (some near the top of the address space), resets
    salt = $urandom; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 700; i++) begin
      ready = $urandom_range(3, 0) != 0;
      redir = $urandom_range(15, 0) == 0;
      rpc   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : {$urandom, 2'b00} >> 0;
      rpc[1:0] = 2'b00;
      if ($urandom_range(199, 0) == 0) do_reset();
      cycle();
    end
    redir = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
